// File: rtl/keypad_event_detector.sv
// Keypad front end: synchronises and debounces a raw key vector, then classifies it
// into single-cycle press / auto-repeat / release / multi-key events.
module keypad_event_detector #(
    parameter int  NUM_KEYS        = 10,
    parameter int  DEBOUNCE_CYCLES = 4,
    parameter int  REPEAT_DELAY    = 0,
    parameter int  REPEAT_RATE     = 8,
    localparam int CODE_W          = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] num,
    output logic                key_valid,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_held,
    output logic                key_release,
    output logic                multi_err
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int T_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam logic [T_W-1:0] DELAY_LAST = T_W'(REPEAT_DELAY - 1);
    localparam logic [T_W-1:0] RATE_LAST  = T_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, MULTI} state_t;

    logic [NUM_KEYS-1:0] s1;
    logic [NUM_KEYS-1:0] s2;
    logic [NUM_KEYS-1:0] cand;
    logic [NUM_KEYS-1:0] deb;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W-1:0]   deb_code;
    logic [T_W-1:0]      timer;
    logic                repeating;
    state_t              state;

    // cnt tracks how many further edges cand has matched s2; deb follows once it saturates
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            deb  <= '0;
            cnt  <= '0;
        end else begin
            s1 <= num;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= cand;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only consumed when deb is one-hot, so OR-ing indices yields the bit position
    always_comb begin
        deb_code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (deb[i]) begin
                deb_code = deb_code | CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            key_valid   <= 1'b0;
            key_onehot  <= '0;
            key_code    <= '0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
            multi_err   <= 1'b0;
            timer       <= '0;
            repeating   <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            multi_err   <= 1'b0;
            case (state)
                IDLE: begin
                    timer     <= '0;
                    repeating <= 1'b0;
                    if ($onehot(deb)) begin
                        state      <= PRESSED;
                        key_valid  <= 1'b1;
                        key_held   <= 1'b1;
                        key_onehot <= deb;
                        key_code   <= deb_code;
                    end else if (deb != '0) begin
                        state     <= MULTI;
                        multi_err <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over a coincident repeat
                    if (deb == '0) begin
                        state       <= IDLE;
                        key_held    <= 1'b0;
                        key_release <= 1'b1;
                        timer       <= '0;
                        repeating   <= 1'b0;
                    end else if (deb != key_onehot) begin
                        state     <= MULTI;
                        key_held  <= 1'b0;
                        multi_err <= 1'b1;
                        timer     <= '0;
                        repeating <= 1'b0;
                    end else if (REPEAT_DELAY > 0) begin
                        if (timer == (repeating ? RATE_LAST : DELAY_LAST)) begin
                            key_valid <= 1'b1;
                            timer     <= '0;
                            repeating <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                MULTI: begin
                    if (deb == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_event_detector.sv
// Bench for keypad_event_detector: a default instance and an auto-repeat instance
// share stimulus and are compared each cycle against a run-length/event-level model.
module tb_keypad_event_detector;
    localparam int NK   = 10;
    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int OW   = NK + CW + 4;
    localparam int RATE = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] num   = '0;

    logic          a_valid, a_held, a_release, a_multi;
    logic [NK-1:0] a_onehot;
    logic [CW-1:0] a_code;
    logic          b_valid, b_held, b_release, b_multi;
    logic [NK-1:0] b_onehot;
    logic [CW-1:0] b_code;

    keypad_event_detector dut_a (
        .clock(clock), .reset(reset), .num(num),
        .key_valid(a_valid), .key_onehot(a_onehot), .key_code(a_code),
        .key_held(a_held), .key_release(a_release), .multi_err(a_multi)
    );

    keypad_event_detector #(.REPEAT_DELAY(20), .REPEAT_RATE(RATE)) dut_b (
        .clock(clock), .reset(reset), .num(num),
        .key_valid(b_valid), .key_onehot(b_onehot), .key_code(b_code),
        .key_held(b_held), .key_release(b_release), .multi_err(b_multi)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: deb is the value seen on DEB+1 consecutive delayed samples;
    // events derive from a held-key index and the elapsed time since the press.
    logic [NK-1:0] hist[$];
    logic [NK-1:0] m_deb;
    int            ecount;
    int            held[2];
    int            press_edge[2];
    logic          e_valid[2], e_rel[2], e_multi[2], e_held[2];
    logic [NK-1:0] e_onehot[2];
    logic [CW-1:0] e_code[2];

    function automatic int rep_delay(input int u);
        return (u == 0) ? 0 : 20;
    endfunction

    task automatic model_fsm(input int u, input logic [NK-1:0] d);
        int n;
        int k;
        int el;
        n = $countones(d);
        k = -1;
        for (int i = 0; i < NK; i++) if (d[i]) k = i;
        e_valid[u] = 1'b0;
        e_rel[u]   = 1'b0;
        e_multi[u] = 1'b0;
        if (held[u] == -1) begin
            if (n == 1) begin
                held[u] = k; e_valid[u] = 1'b1; e_onehot[u] = d;
                e_code[u] = CW'(k); press_edge[u] = ecount;
            end else if (n > 1) begin
                held[u] = -2; e_multi[u] = 1'b1;
            end
        end else if (held[u] == -2) begin
            if (n == 0) held[u] = -1;
        end else begin
            if (n == 0) begin
                held[u] = -1; e_rel[u] = 1'b1;
            end else if (d != (NK'(1) << held[u])) begin
                held[u] = -2; e_multi[u] = 1'b1;
            end else if (rep_delay(u) > 0) begin
                el = ecount - press_edge[u];
                if (el >= rep_delay(u) && (el - rep_delay(u)) % RATE == 0) e_valid[u] = 1'b1;
            end
        end
        e_held[u] = (held[u] >= 0);
    endtask

    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_deb  = '0;
            ecount = 0;
            hist.delete();
            for (int i = 0; i < DEB + 3; i++) hist.push_back('0);
            for (int u = 0; u < 2; u++) begin
                held[u] = -1; press_edge[u] = 0;
                e_valid[u] = 1'b0; e_rel[u] = 1'b0; e_multi[u] = 1'b0; e_held[u] = 1'b0;
                e_onehot[u] = '0; e_code[u] = '0;
            end
        end else begin
            ecount++;
            for (int u = 0; u < 2; u++) model_fsm(u, m_deb);
            hist.push_back(num);
            void'(hist.pop_front());
            begin
                bit stable;
                stable = 1'b1;
                for (int i = 1; i <= DEB; i++) if (hist[i] !== hist[0]) stable = 1'b0;
                if (stable) m_deb = hist[0];
            end
        end
    end

    wire [OW-1:0] obs_a = {a_valid, a_release, a_multi, a_held, a_onehot, a_code};
    wire [OW-1:0] obs_b = {b_valid, b_release, b_multi, b_held, b_onehot, b_code};
    wire [OW-1:0] exp_a = {e_valid[0], e_rel[0], e_multi[0], e_held[0], e_onehot[0], e_code[0]};
    wire [OW-1:0] exp_b = {e_valid[1], e_rel[1], e_multi[1], e_held[1], e_onehot[1], e_code[1]};

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (obs_a !== '0 || obs_b !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h required 0", obs_a, obs_b);
        end
        reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL reset_idle c=%0d: got a=%h b=%h required a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_clean_press();
        int first_v = -1, nv = 0, first_r = -1, nr = 0, held_lo = 0;
        logic [CW-1:0] code_at = '0;
        logic [NK-1:0] oh_at = '0;
        num = NK'(1) << 3;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL clean_model c=%0d: got a=%h b=%h required a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
            end
            if (a_valid) begin
                nv++;
                if (first_v < 0) begin first_v = c - 1; code_at = a_code; oh_at = a_onehot; end
            end
            if (a_release) begin nr++; if (first_r < 0) first_r = c - 21; end
            if (c >= 8 && c <= 27 && a_held !== 1'b1) held_lo++;
            if (c == 20) num = '0;
        end
        checks++;
        if (first_v != 7 || nv != 1) begin
            errors++; $display("FAIL clean_press_latency: got lat=%0d count=%0d required 7/1", first_v, nv);
        end
        checks++;
        if (code_at !== 4'd3 || oh_at !== 10'h008) begin
            errors++; $display("FAIL clean_press_key: got code=%0d onehot=%h required 3/008", code_at, oh_at);
        end
        checks++;
        if (first_r != 7 || nr != 1 || held_lo != 0) begin
            errors++; $display("FAIL clean_release: got lat=%0d count=%0d held_gaps=%0d required 7/1/0", first_r, nr, held_lo);
        end
    endtask

    task automatic test_glitch();
        int act = 0, nv = 0;
        logic [CW-1:0] code_at = '0;
        for (int g = 4; g <= 5; g++) begin
            num = NK'(1) << 5;
            for (int c = 1; c <= 30; c++) begin
                @(negedge clock);
                checks++;
                if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                    errors++;
                    $display("FAIL glitch_model g=%0d c=%0d: got a=%h b=%h required a=%h b=%h", g, c, obs_a, obs_b, exp_a, exp_b);
                end
                if (g == 4 && (a_valid | a_release | a_multi | a_held)) act++;
                if (g == 5 && a_valid) begin nv++; code_at = a_code; end
                if (c == g) num = '0;
            end
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL glitch_short: got %0d active cycles required 0", act);
        end
        checks++;
        if (nv != 1 || code_at !== 4'd5) begin
            errors++; $display("FAIL glitch_long: got count=%0d code=%0d required 1/5", nv, code_at);
        end
    endtask

    task automatic test_multi_key();
        int nv_first = 0, nv_later = 0, nm = 0, nr = 0;
        logic held_mid = 1'b1;
        num = NK'(1) << 2;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL multi_model c=%0d: got a=%h b=%h required a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
            end
            if (a_valid) begin if (c <= 15) nv_first++; else nv_later++; end
            if (a_multi) nm++;
            if (a_release) nr++;
            if (c == 30) held_mid = a_held;
            if (c == 15) num = (NK'(1) << 2) | (NK'(1) << 7);
            if (c == 30) num = NK'(1) << 2;
            if (c == 45) num = '0;
        end
        checks++;
        if (nv_first != 1 || nv_later != 0) begin
            errors++; $display("FAIL multi_valid: got first=%0d later=%0d required 1/0", nv_first, nv_later);
        end
        checks++;
        if (nm != 1 || nr != 0 || held_mid !== 1'b0) begin
            errors++; $display("FAIL multi_events: got multi=%0d release=%0d held=%b required 1/0/0", nm, nr, held_mid);
        end
    endtask

    task automatic test_repeat();
        int got[$];
        int want[6] = '{8, 28, 36, 44, 52, 60};
        int bad_code = 0, nva = 0;
        num = NK'(1) << 9;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL repeat_model c=%0d: got a=%h b=%h required a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
            end
            if (b_valid) begin got.push_back(c); if (b_code !== 4'd9) bad_code++; end
            if (a_valid) nva++;
            if (c == 60) num = '0;
        end
        checks++;
        if (got.size() != 6 || bad_code != 0 || nva != 1) begin
            errors++; $display("FAIL repeat_count: got %0d pulses bad_codes=%0d a_pulses=%0d required 6/0/1", got.size(), bad_code, nva);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got[i] != want[i]) begin
                    errors++; $display("FAIL repeat_time[%0d]: got cycle %0d required %0d", i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int nv = 0, nm = 0;
        num = NK'(3);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL simul_model c=%0d: got a=%h b=%h required a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
            end
            if (a_valid) nv++;
            if (a_multi) nm++;
            if (c == 15) num = '0;
        end
        checks++;
        if (nv != 0 || nm != 1 || a_code !== 4'd9 || a_onehot !== 10'h200) begin
            errors++; $display("FAIL simul_events: got valid=%0d multi=%0d code=%0d onehot=%h required 0/1/9/200", nv, nm, a_code, a_onehot);
        end
    endtask

    task automatic test_reset_midpress();
        int first_v = -1;
        logic [CW-1:0] code_at = '0;
        num = NK'(1) << 4;
        repeat (12) @(negedge clock);
        checks++;
        if (a_held !== 1'b1 || a_code !== 4'd4) begin
            errors++; $display("FAIL midpress_held: got held=%b code=%0d required 1/4", a_held, a_code);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs_a !== '0 || obs_b !== '0) begin
            errors++; $display("FAIL midpress_async: got a=%h b=%h required 0", obs_a, obs_b);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clock);
            checks++;
            if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL midpress_model c=%0d: got a=%h b=%h required a=%h b=%h", c, obs_a, obs_b, exp_a, exp_b);
            end
            if (a_valid && first_v < 0) begin first_v = c - 1; code_at = a_code; end
            if (c == 12) num = '0;
        end
        checks++;
        if (first_v != 7 || code_at !== 4'd4) begin
            errors++; $display("FAIL midpress_repress: got lat=%0d code=%0d required 7/4", first_v, code_at);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 150; s++) begin
            int r;
            int len;
            r = $urandom_range(0, 9);
            len = $urandom_range(1, 25);
            if (r < 2) num = '0;
            else if (r < 8) begin
                num = NK'(1) << $urandom_range(0, NK - 1);
                if ($urandom_range(0, 3) == 0) len = $urandom_range(30, 70);
            end
            else if (r == 8) num = (NK'(1) << $urandom_range(0, NK - 1)) | (NK'(1) << $urandom_range(0, NK - 1));
            else num = NK'($urandom);
            for (int c = 0; c < len; c++) begin
                @(negedge clock);
                checks++;
                if ({obs_a, obs_b} !== {exp_a, exp_b}) begin
                    errors++;
                    $display("FAIL random_model seg=%0d num=%h: got a=%h b=%h required a=%h b=%h", s, num, obs_a, obs_b, exp_a, exp_b);
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_multi_key();
        test_repeat();
        test_simultaneous();
        test_reset_midpress();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
